ram_arbiter_2p: RTL and testbench
=================================

RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DW  16  data width
  AW  4   address width (2**AW words)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk         in   1   sole clock, rising edge
  rst         in   1   synchronous, active-high reset
  req_a       in   1   requester A access request
  we_a        in   1   A: 1 = write, 0 = read
  addr_a      in   AW  A address
  wdata_a     in   DW  A write data
  gnt_a       out  1   A request accepted (1-cycle pulse)
  rvalid_a    out  1   A read data valid (1-cycle pulse)
  rdata_a     out  DW  A read data
  req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
  ram_r_en    out  1   RAM read strobe
  ram_w_en    out  1   RAM write strobe
  ram_address out  AW  RAM address
  ram_data_in out  DW  RAM write data
  ram_d_out   in   DW  RAM registered read data (1-cycle latency; high-Z when not reading)
  busy        out  1   high when state is not IDLE
REQ-003 The clock SHALL be the only clock; reset SHALL be synchronous and active-high.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 FSM states SHALL be IDLE, ACCESS, RDWAIT.
REQ-006 IDLE: no req -> stay IDLE. Any req -> latch the winner's we/addr/wdata and owner, pulse gnt_<owner>, drive ram_address/ram_data_in, assert exactly one of ram_r_en/ram_w_en, go to ACCESS. All of this SHALL be visible in the cycle after the request is sampled.
REQ-007 ACCESS lasts one cycle with the strobe high. Write -> IDLE. Read -> RDWAIT. Strobes SHALL deassert on leaving ACCESS.
REQ-008 RDWAIT lasts one cycle: capture ram_d_out into rdata_<owner>, pulse rvalid_<owner> the next cycle, go to IDLE.
REQ-009 Latency from req sampled in IDLE: gnt at +1. Write completes in the RAM at the end of +1, next arbitration at +2. rvalid/rdata at +3, next arbitration at +3.
REQ-010 ram_r_en and ram_w_en SHALL never be high together.
REQ-011 Requests SHALL be sampled only in IDLE. req held high while not IDLE waits, with no loss and no gnt.
REQ-012 A requester SHALL hold we/addr/wdata stable while req is high and ungranted. A req still high in the cycle after gnt SHALL count as a new request.
REQ-013 Arbitration: if only one req, grant it. If both, grant the requester not granted most recently (round-robin). The last-granted pointer SHALL update on every grant.
REQ-014 Under continuous requests from both sides, grants SHALL strictly alternate A, B, A, B.
REQ-015 rdata_x SHALL hold its last captured value until that requester's next read completes. It SHALL not be altered by the other requester's accesses.
REQ-016 gnt_a/gnt_b and rvalid_a/rvalid_b SHALL never be high in the same cycle.
REQ-017 busy SHALL be high in ACCESS and RDWAIT and in no other state.

Reset
REQ-018 On rst high at a clock edge:
  - state -> IDLE
  - gnt, rvalid, ram_r_en, ram_w_en, busy -> 0
  - ram_address, ram_data_in, rdata_a, rdata_b -> 0
  - last-granted pointer -> B, so A wins the first tie
REQ-019 Reset mid-operation SHALL abort the access: no rvalid SHALL follow, strobes SHALL be low the next cycle, and a write already in ACCESS may have completed in the RAM.
REQ-020 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-021 Reset, then A writes addr 3 = 0xBEEF -> gnt_a at +1, ram_w_en one cycle with ram_address=3, busy low at +2.
REQ-022 Then A reads addr 3 -> ram_r_en one cycle, rvalid_a at +3 with rdata_a=0xBEEF, rdata_b unchanged.
REQ-023 First cycle after reset, req_a and req_b both high (writes) -> gnt_a first. Held requests -> gnt_b next, then alternation A, B, A, B over 8 grants.
REQ-024 B writes 0x1234 to addr 15, then A reads addr 15 while req_b stays asserted -> wrap address handled, rdata_a=0x1234, B waits and is granted on the next arbitration.
REQ-025 rst asserted in RDWAIT of an A read -> no rvalid_a, busy=0 and all strobes 0 the next cycle, the next tie grants A.
REQ-026 Assertion checks on every cycle: never r_en&w_en, never gnt_a&gnt_b, never rvalid_a&rvalid_b.

Source files
------------

// File: rtl/ram_arbiter_2p_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_2p_if
//  Purpose  : Bundles the two requester ports and the single-port RAM port
//             of the two-way RAM arbiter.
//  Ports    : requester A/B  - req, we, addr, wdata in; gnt, rvalid, rdata out
//             RAM            - r_en, w_en, address, data_in out; d_out in
//             status         - busy out
//  Modports : slave  - arbiter view
//             master - environment view (requesters + RAM)
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_2p_if #(
  parameter int DW = 16,
  parameter int AW = 4
) ();
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;

  logic          ram_r_en;
  logic          ram_w_en;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_d_out;

  logic          busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  ram_d_out,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output ram_r_en, ram_w_en, ram_address, ram_data_in,
    output busy
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output ram_d_out,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  ram_r_en, ram_w_en, ram_address, ram_data_in,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_2p
//  Purpose  : Round-robin arbiter giving two requesters access to one
//             single-port RAM with registered (1-cycle) read data.
//             IDLE -> ACCESS (strobe high one cycle) -> [RDWAIT for reads]
//             -> IDLE. All outputs are registered.
//  Ports    : clk  - sole clock, rising edge
//             rst  - synchronous, active-high reset
//             bus  - ram_arbiter_2p_if.slave (requesters, RAM, busy)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter_2p #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  ram_arbiter_2p_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state;
  logic   owner_b;   // owner of the access in flight: 1 = B, 0 = A
  logic   we_q;      // direction of the access in flight
  logic   last_b;    // most recently granted requester: 1 = B, 0 = A
  logic   pick_b;

  // B wins when it is alone, or on a tie when A was granted last.
  assign pick_b = bus.req_b & (~bus.req_a | ~last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner_b         <= 1'b0;
      we_q            <= 1'b0;
      last_b          <= 1'b1;
      bus.gnt_a       <= 1'b0;
      bus.gnt_b       <= 1'b0;
      bus.rvalid_a    <= 1'b0;
      bus.rvalid_b    <= 1'b0;
      bus.rdata_a     <= {DW{1'b0}};
      bus.rdata_b     <= {DW{1'b0}};
      bus.ram_r_en    <= 1'b0;
      bus.ram_w_en    <= 1'b0;
      bus.ram_address <= {AW{1'b0}};
      bus.ram_data_in <= {DW{1'b0}};
      bus.busy        <= 1'b0;
    end else begin
      // Pulsed outputs default low; only the state that owns them raises them.
      bus.gnt_a    <= 1'b0;
      bus.gnt_b    <= 1'b0;
      bus.rvalid_a <= 1'b0;
      bus.rvalid_b <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req_a | bus.req_b) begin
            owner_b  <= pick_b;
            last_b   <= pick_b;
            bus.busy <= 1'b1;
            state    <= ACCESS;
            if (pick_b) begin
              we_q            <= bus.we_b;
              bus.gnt_b       <= 1'b1;
              bus.ram_address <= bus.addr_b;
              bus.ram_data_in <= bus.wdata_b;
              bus.ram_w_en    <= bus.we_b;
              bus.ram_r_en    <= ~bus.we_b;
            end else begin
              we_q            <= bus.we_a;
              bus.gnt_a       <= 1'b1;
              bus.ram_address <= bus.addr_a;
              bus.ram_data_in <= bus.wdata_a;
              bus.ram_w_en    <= bus.we_a;
              bus.ram_r_en    <= ~bus.we_a;
            end
          end
        end

        ACCESS: begin
          bus.ram_r_en <= 1'b0;
          bus.ram_w_en <= 1'b0;
          if (we_q) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state    <= RDWAIT;
          end
        end

        RDWAIT: begin
          // RAM data launched by the ACCESS-cycle strobe is valid now.
          if (owner_b) begin
            bus.rdata_b  <= bus.ram_d_out;
            bus.rvalid_b <= 1'b1;
          end else begin
            bus.rdata_a  <= bus.ram_d_out;
            bus.rvalid_a <= 1'b1;
          end
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.ram_r_en <= 1'b0;
          bus.ram_w_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter_2p
//  Purpose  : Self-checking bench for ram_arbiter_2p with a behavioural
//             registered-read RAM and a read-data scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter_2p;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_2p_if #(.DW(16), .AW(4)) bus ();

  ram_arbiter_2p #(.DW(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: write on w_en, registered read on r_en, garbage otherwise
  // so that a capture at the wrong cycle is visible.
  logic [15:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
  always @(posedge clk) begin
    if (bus.ram_w_en) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_d_out <= bus.ram_r_en ? mem[bus.ram_address] : 16'hDEAD;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // {owner_b, data} of each read expected to complete, in issue order.
  logic [16:0] sb [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Per-cycle invariants and read-data scoreboard.
  logic [16:0] ent;
  always @(negedge clk) begin
    check_eq("rw_excl",  {31'd0, bus.ram_r_en & bus.ram_w_en}, 32'd0);
    check_eq("gnt_excl", {31'd0, bus.gnt_a & bus.gnt_b}, 32'd0);
    check_eq("rv_excl",  {31'd0, bus.rvalid_a & bus.rvalid_b}, 32'd0);
    if (bus.rvalid_a | bus.rvalid_b) begin
      if (sb.size() == 0) begin
        check_eq("rv_unexpected", 32'd1, 32'd0);
      end else begin
        ent = sb.pop_front();
        check_eq("rv_owner", {31'd0, bus.rvalid_b}, {31'd0, ent[16]});
        check_eq("rv_data", {16'd0, ent[16] ? bus.rdata_b : bus.rdata_a}, {16'd0, ent[15:0]});
      end
    end
  end

  int ng;
  int first_i;

  initial begin
    rst = 1'b1;
    bus.req_a = 0; bus.we_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
    bus.req_b = 0; bus.we_b = 0; bus.addr_b = 0; bus.wdata_b = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_gnt",   {30'd0, bus.gnt_a, bus.gnt_b}, 32'd0);
    check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("rst_strb",  {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd0);
    check_eq("rst_addr",  {28'd0, bus.ram_address}, 32'd0);
    check_eq("rst_din",   {16'd0, bus.ram_data_in}, 32'd0);
    check_eq("rst_rdata", {bus.rdata_a, bus.rdata_b}, 32'd0);

    // A writes 0xBEEF to address 3
    rst = 1'b0;
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4'd3; bus.wdata_a = 16'hBEEF;
    @(negedge clk);
    check_eq("wr_gnt_a", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
    check_eq("wr_strb",  {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd1);
    check_eq("wr_addr",  {28'd0, bus.ram_address}, 32'd3);
    check_eq("wr_din",   {16'd0, bus.ram_data_in}, 32'h0000BEEF);
    check_eq("wr_busy1", {31'd0, bus.busy}, 32'd1);
    bus.req_a = 0;
    @(negedge clk);
    check_eq("wr_busy2", {31'd0, bus.busy}, 32'd0);
    check_eq("wr_strb2", {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd0);

    // A reads address 3
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'd3;
    sb.push_back({1'b0, 16'hBEEF});
    @(negedge clk);
    check_eq("rd_gnt_a", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
    check_eq("rd_strb",  {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd2);
    bus.req_a = 0;
    @(negedge clk);
    check_eq("rd_wait_strb", {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd0);
    check_eq("rd_wait_rv",   {31'd0, bus.rvalid_a}, 32'd0);
    check_eq("rd_wait_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check_eq("rd_rv_a",   {31'd0, bus.rvalid_a}, 32'd1);
    check_eq("rd_busy",   {31'd0, bus.busy}, 32'd0);
    check_eq("rd_rdatab", {16'd0, bus.rdata_b}, 32'd0);

    // Tie straight out of reset, held requests alternate A,B,...
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4'd1; bus.wdata_a = 16'hA001;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 4'd2; bus.wdata_b = 16'hB002;
    ng = 0;
    first_i = -1;
    for (int i = 0; i < 40 && ng < 8; i++) begin
      @(negedge clk);
      if (bus.gnt_a | bus.gnt_b) begin
        if (ng == 0) first_i = i;
        check_eq("alt_side", {31'd0, bus.gnt_b}, ng % 2);
        ng++;
      end
    end
    bus.req_a = 0; bus.req_b = 0;
    check_eq("alt_count", ng, 32'd8);
    check_eq("tie_latency", first_i, 32'd0);
    @(negedge clk);

    // B reads address 2 so rdata_b holds a known value
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'd2;
    sb.push_back({1'b1, 16'hB002});
    @(negedge clk);
    check_eq("rdb_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd1);
    bus.req_b = 0;
    repeat (2) @(negedge clk);

    // B writes 0x1234 to the top address
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 4'd15; bus.wdata_b = 16'h1234;
    @(negedge clk);
    check_eq("wrb_gnt",  {30'd0, bus.gnt_a, bus.gnt_b}, 32'd1);
    check_eq("wrb_addr", {28'd0, bus.ram_address}, 32'd15);
    bus.req_b = 0;
    @(negedge clk);

    // A reads address 15 while B holds a new write request
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'd15;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 4'd14; bus.wdata_b = 16'h5555;
    sb.push_back({1'b0, 16'h1234});
    @(negedge clk);
    check_eq("rr_gnt_a", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
    check_eq("rr_addr",  {28'd0, bus.ram_address}, 32'd15);
    bus.req_a = 0;
    @(negedge clk);
    check_eq("rr_wait1", {31'd0, bus.gnt_b}, 32'd0);
    @(negedge clk);
    check_eq("rr_wait2",  {31'd0, bus.gnt_b}, 32'd0);
    check_eq("rr_rv_a",   {31'd0, bus.rvalid_a}, 32'd1);
    check_eq("rr_rdatab", {16'd0, bus.rdata_b}, 32'h0000B002);
    @(negedge clk);
    check_eq("rr_gnt_b", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd1);
    check_eq("rr_wb",    {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd1);
    check_eq("rr_waddr", {28'd0, bus.ram_address}, 32'd14);
    bus.req_b = 0;
    @(negedge clk);

    // Reset during RDWAIT of an A read aborts it
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'd3;
    @(negedge clk);
    check_eq("ab_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
    bus.req_a = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ab_rv",    {31'd0, bus.rvalid_a}, 32'd0);
    check_eq("ab_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("ab_strb",  {30'd0, bus.ram_r_en, bus.ram_w_en}, 32'd0);
    check_eq("ab_rdata", {16'd0, bus.rdata_a}, 32'd0);
    rst = 1'b0;
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4'd5; bus.wdata_a = 16'h0055;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 4'd6; bus.wdata_b = 16'h0066;
    @(negedge clk);
    check_eq("ab_tie_a", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd2);
    bus.req_a = 0; bus.req_b = 0;
    repeat (4) @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
